cyc_enc_serial: RTL and testbench
=================================

Name: cyc_enc_serial

Overview:
- Parametrised, bit-serial, systematic cyclic-code encoder with valid/ready streaming on both sides.
- Generalises the fixed (15,7) combinational encoder to any (N,K) code with a generator polynomial g(x) of degree N-K.
- Uses an LFSR division circuit. Each codeword is streamed out bit-serially as K message bits followed by N-K parity bits.
- Also presents the completed codeword in parallel, for the downstream decoder test path.

Parameters:
- N, 15, codeword length in bits (N > K >= 1).
- K, 7, message length in bits.
- G_POLY, 9'h1D1, generator polynomial, N-K+1 bits; bit i = coefficient of x^i. Bits N-K and 0 must be 1. Default is x^8+x^7+x^6+x^4+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous abort of the current codeword.
- in_valid  in  1  message bit valid.
- in_ready  out  1  encoder accepts a message bit.
- in_bit  in  1  message bit. Highest-degree bit first: m[K-1] first, m[0] last.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  sink accepts out_bit.
- out_bit  out  1  codeword bit, highest degree first.
- out_last  out  1  high with the final (parity r[0]) bit of a codeword.
- cw_out  out  N  last completed codeword; bit i = coefficient of x^i.
- cw_valid  out  1  one-cycle pulse when cw_out updates.

Behaviour:
- Code definition: c(x) = m(x)·x^(N-K) + r(x), where r(x) = m(x)·x^(N-K) mod g(x).
- Internal state: parity register par[N-K-1:0], bit counter cnt (width clog2(N)), state MSG/PAR, cw shift register.
- Reset (rst_n=0 at an edge): state=MSG, cnt=0, par=0. Outputs out_valid=0, out_bit=0, out_last=0, cw_out=0, cw_valid=0. in_ready is 0 while rst_n=0.
- Output register: single stage. It is "free" when out_valid=0 or out_ready=1.
- in_ready = (state==MSG) && free && !clr && rst_n. Combinational.
- MSG, on in_valid && in_ready:
  - out_bit <= in_bit, out_valid <= 1.
  - fb = in_bit ^ par[N-K-1].
  - par <= {par[N-K-2:0],0} ^ (fb ? G_POLY[N-K-1:0] : 0).
  - cnt++.
  - If cnt==K-1 before the increment: state <= PAR, cnt <= 0.
- MSG with no input handshake: if out_ready && out_valid, then out_valid <= 0.
- PAR, when free:
  - out_bit <= par[N-K-1], par <= {par[N-K-2:0],0}, out_valid <= 1, cnt++.
  - On the (N-K)th parity bit: out_last <= 1, state <= MSG, cnt <= 0.
  - par is zero again after the final shift.
- out_last clears when its bit handshakes, unless it is replaced by a new bit.
- Back-to-back operation: the first message bit of the next codeword is accepted in the same cycle the out_last bit handshakes. No bubble is required.
- Throughput: one codeword every N cycles with continuous valid/ready. Latency from input accept to out_valid is 1 cycle.
- Holding under backpressure: out_valid, out_bit and out_last stay stable while out_valid && !out_ready.
- cw_out and cw_valid:
  - Every loaded output bit also shifts into the cw shift register.
  - When the out_last bit handshakes: cw_out <= full codeword, with the first-sent bit at cw_out[N-1]. cw_valid pulses 1 in the next cycle.
  - cw_out holds its value otherwise.
- clr=1 at an edge: same as reset except cw_out is retained. Any in-flight output bit is dropped (out_valid=0). clr has priority over handshakes in the same cycle.
- Reset or clr mid-codeword: the partial codeword is discarded. The next accepted bit is m[K-1] of a new codeword.
- Elaboration: $error if G_POLY[N-K] != 1 or G_POLY[0] != 1, or if K >= N.

Test Plan:
- Reset then all-zero message (7 zeros, out_ready=1) -> 15 output bits all 0, out_last on the 15th, cw_valid pulse, cw_out=15'h0000.
- Message 0,0,0,0,0,0,1 (m(x)=1) -> parity bits 1,1,0,1,0,0,0,1 (r=8'hD1), cw_out=15'h01D1.
- Message 1,0,0,0,0,0,0 (m(x)=x^6) -> cw_out=15'h40E8. Message all ones -> cw_out=15'h7FFF.
- Random out_ready backpressure (~50%) over 100 random back-to-back messages:
  - Serial stream and cw_out match a reference model.
  - No bit is lost or duplicated; out_bit is stable while stalled.
  - in_ready is never high during PAR.
- clr asserted after 3 message bits, then message 0,0,0,0,0,0,1 -> out_valid drops the next cycle, cw_out keeps its previous value, then 15'h01D1 is produced. Repeat with rst_n low mid-parity -> all outputs 0.
- Re-parametrise N=7, K=4, G_POLY=4'hB (Hamming) -> message 0,0,0,1 gives cw_out=7'h0B. Exhaustive 16 messages match the model.

Source files
------------

// File: rtl/cyc_enc_serial.sv
// cyc_enc_serial: bit-serial systematic cyclic-code encoder (LFSR division) with valid/ready streams and a parallel codeword copy
module cyc_enc_serial #(
    parameter int N = 15,
    parameter int K = 7,
    parameter logic [N-K:0] G_POLY = 9'h1D1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_last,
    output logic [N-1:0] cw_out,
    output logic         cw_valid
);
    localparam int P = N - K;
    localparam int CW = $clog2(N);

    typedef enum logic {MSG, PAR} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [P-1:0]  par;
    logic [N-1:0]  sr;
    logic          free, out_hs, ld, nb, fb, wrap;

    if (K < 1 || K >= N || G_POLY[P] != 1'b1 || G_POLY[0] != 1'b1) begin : g_bad_params
        $error("cyc_enc_serial: need N > K >= 1 and G_POLY with top and constant coefficients set");
    end

    assign free     = !out_valid || out_ready;
    assign in_ready = state == MSG && free && !clr && rst_n;
    assign out_hs   = out_valid && out_ready;
    assign ld       = (in_valid && in_ready) || (state == PAR && free);
    assign nb       = state == MSG ? in_bit : par[P-1];
    assign fb       = in_bit ^ par[P-1];
    assign wrap     = cnt == (state == MSG ? CW'(K - 1) : CW'(P - 1));

    // Single-stage output register: message bits pass through while the LFSR divides, then the remainder is shifted out
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= MSG;
            cnt       <= '0;
            par       <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            cw_valid  <= 1'b0;
            if (!rst_n) cw_out <= '0;
        end else begin
            cw_valid <= out_hs && out_last;
            if (out_hs && out_last) cw_out <= sr;
            if (ld) begin
                out_bit   <= nb;
                out_valid <= 1'b1;
                out_last  <= state == PAR && wrap;
                sr        <= {sr[N-2:0], nb};
                par       <= (par << 1) ^ (state == MSG && fb ? G_POLY[P-1:0] : '0);
                cnt       <= wrap ? '0 : cnt + CW'(1);
                if (wrap) state <= state == MSG ? PAR : MSG;
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cyc_enc_serial.sv
// tb_cyc_enc_serial: directed and randomised-backpressure checks of the serial cyclic encoder, plus a (7,4) Hamming instance
module tb_cyc_enc_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, clr = 1'b0;
    logic        in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_bit, out_last, cw_valid;
    logic [14:0] cw_out;
    logic        h_in_valid = 1'b0, h_in_bit = 1'b0;
    logic        h_in_ready, h_out_valid, h_out_bit, h_out_last, h_cw_valid;
    logic [6:0]  h_cw_out;

    int          tests = 0, fails = 0;
    logic        rx_bits[$], rx_last[$];
    logic [14:0] rx_cw[$], msgq[$];
    int          anomalies, cyc;
    bit          timeout;

    always #5 clk = ~clk;

    cyc_enc_serial dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
        .cw_out(cw_out), .cw_valid(cw_valid)
    );

    cyc_enc_serial #(.N(7), .K(4), .G_POLY(4'hB)) dut_h (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_bit(h_in_bit),
        .out_valid(h_out_valid), .out_ready(1'b1), .out_bit(h_out_bit), .out_last(h_out_last),
        .cw_out(h_cw_out), .cw_valid(h_cw_valid)
    );

    // Reference codeword by polynomial long division of m(x)*x^(n-k) by g(x)
    function automatic logic [31:0] model(input logic [31:0] m, input int n, input int k, input logic [31:0] g);
        logic [31:0] r = m << (n - k);
        for (int i = n - 1; i >= n - k; i--)
            if (r[i]) r = r ^ (g << (i - (n - k)));
        return (m << (n - k)) | r;
    endfunction

    function automatic int stream_errs();
        int e = (rx_bits.size() != msgq.size() * 15) ? 1000 : 0;
        logic [14:0] c;
        for (int i = 0; i < rx_bits.size() && i < msgq.size() * 15; i++) begin
            c = 15'(model(32'(msgq[i / 15]), 15, 7, 32'h1D1));
            if (rx_bits[i] !== c[14 - i % 15] || rx_last[i] !== (i % 15 == 14)) e++;
        end
        return e;
    endfunction

    function automatic int cw_errs();
        int e = (rx_cw.size() != msgq.size()) ? 1 : 0;
        for (int i = 0; i < rx_cw.size() && i < msgq.size(); i++)
            if (rx_cw[i] !== 15'(model(32'(msgq[i]), 15, 7, 32'h1D1))) e++;
        return e;
    endfunction

    // Feeds every message in msgq and records the output stream and codeword pulses
    task automatic stream(input bit bp, input int budget);
        int          bi = 0, acc = 0;
        int          total = msgq.size() * 7;
        bit          stalled = 1'b0;
        logic        sb = 1'b0, sl = 1'b0;
        logic [14:0] m;
        rx_bits.delete(); rx_last.delete(); rx_cw.delete();
        anomalies = 0; cyc = 0;
        while (rx_cw.size() < msgq.size() && cyc < budget) begin
            @(negedge clk);
            if (stalled && (out_valid !== 1'b1 || out_bit !== sb || out_last !== sl)) anomalies++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = bi < total;
            if (bi < total) begin
                m = msgq[bi / 7];
                in_bit = m[6 - bi % 7];
            end
            #1;
            stalled = out_valid && !out_ready;
            sb = out_bit;
            sl = out_last;
            if (out_valid && out_ready) begin
                rx_bits.push_back(out_bit);
                rx_last.push_back(out_last);
                if (out_last) acc = 0;
            end
            if (acc == 7 && in_ready) anomalies++;
            if (in_valid && in_ready) begin
                bi++;
                acc++;
            end
            if (cw_valid) rx_cw.push_back(cw_out);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        timeout = rx_cw.size() < msgq.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        tests++; if (out_bit !== 1'b0) begin fails++; $display("FAIL reset_out_bit: got %b exp 0", out_bit); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b exp 0", out_last); end
        tests++; if (cw_out !== 15'h0) begin fails++; $display("FAIL reset_cw_out: got %h exp 0000", cw_out); end
        tests++; if (cw_valid !== 1'b0) begin fails++; $display("FAIL reset_cw_valid: got %b exp 0", cw_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [14:0] msgs [4] = '{15'h00, 15'h01, 15'h40, 15'h7F};
        logic [14:0] exps [4] = '{15'h0000, 15'h01D1, 15'h40E8, 15'h7FFF};
        logic [14:0] got, ex;
        int e;
        for (int t = 0; t < 4; t++) begin
            msgq = '{msgs[t]};
            stream(1'b0, 100);
            ex = exps[t];
            got = rx_cw.size() > 0 ? rx_cw[0] : 'x;
            tests++; if (timeout) begin fails++; $display("FAIL directed_timeout[%0d]: got %0d codewords exp 1", t, rx_cw.size()); end
            tests++; if (got !== ex) begin fails++; $display("FAIL directed_cw[%0d]: got %h exp %h", t, got, ex); end
            e = rx_bits.size() != 15 ? 99 : 0;
            for (int i = 0; i < rx_bits.size() && i < 15; i++)
                if (rx_bits[i] !== ex[14 - i] || rx_last[i] !== (i == 14)) e++;
            tests++; if (e !== 0) begin fails++; $display("FAIL directed_bits[%0d]: got %0d bit errors exp 0", t, e); end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        msgq = '{15'h01, 15'h40, 15'h55};
        stream(1'b0, 200);
        tests++; if (cyc !== 47) begin fails++; $display("FAIL b2b_cycles: got %0d exp 47", cyc); end
        e = stream_errs();
        tests++; if (e !== 0) begin fails++; $display("FAIL b2b_bits: got %0d errors exp 0", e); end
        e = cw_errs();
        tests++; if (e !== 0) begin fails++; $display("FAIL b2b_cw: got %0d errors exp 0", e); end
    endtask

    task automatic test_random_backpressure();
        int e;
        msgq.delete();
        for (int i = 0; i < 100; i++) msgq.push_back(15'($urandom_range(0, 127)));
        stream(1'b1, 20000);
        tests++; if (timeout) begin fails++; $display("FAIL rand_timeout: got %0d codewords exp 100", rx_cw.size()); end
        e = stream_errs();
        tests++; if (e !== 0) begin fails++; $display("FAIL rand_bits: got %0d errors exp 0", e); end
        e = cw_errs();
        tests++; if (e !== 0) begin fails++; $display("FAIL rand_cw: got %0d errors exp 0", e); end
        tests++; if (anomalies !== 0) begin fails++; $display("FAIL rand_stall_or_par_ready: got %0d events exp 0", anomalies); end
        tests++; if (rx_bits.size() !== 1500) begin fails++; $display("FAIL rand_count: got %0d bits exp 1500", rx_bits.size()); end
    endtask

    task automatic test_clr();
        logic [14:0] got;
        msgq = '{15'h40};
        stream(1'b0, 100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit = 1'b0;
        end
        @(negedge clk);
        clr = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL clr_in_ready: got %b exp 0", in_ready); end
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_drop: got %b exp 0", out_valid); end
        tests++; if (cw_out !== 15'h40E8) begin fails++; $display("FAIL clr_keep_cw: got %h exp 40e8", cw_out); end
        msgq = '{15'h01};
        stream(1'b0, 100);
        got = rx_cw.size() > 0 ? rx_cw[0] : 'x;
        tests++; if (got !== 15'h01D1) begin fails++; $display("FAIL clr_after_cw: got %h exp 01d1", got); end
        tests++; if (stream_errs() !== 0) begin fails++; $display("FAIL clr_after_bits: got %0d errors exp 0", stream_errs()); end
    endtask

    task automatic test_rst_mid();
        logic [14:0] got;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = i < 7;
            in_bit = i == 6;
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_in_ready: got %b exp 0", in_ready); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_last !== 1'b0) begin fails++; $display("FAIL rst_mid_out: got %b%b%b exp 000", out_valid, out_bit, out_last); end
        tests++; if (cw_out !== 15'h0) begin fails++; $display("FAIL rst_mid_cw: got %h exp 0000", cw_out); end
        rst_n = 1'b1;
        msgq = '{15'h40};
        stream(1'b0, 100);
        got = rx_cw.size() > 0 ? rx_cw[0] : 'x;
        tests++; if (got !== 15'h40E8) begin fails++; $display("FAIL rst_mid_after_cw: got %h exp 40e8", got); end
    endtask

    task automatic test_hamming();
        int hb = 0, hc = 0, e = 0;
        logic [6:0] got[$];
        logic [6:0] first;
        while (got.size() < 16 && hc < 400) begin
            @(negedge clk);
            h_in_valid = hb < 64;
            h_in_bit = hb < 64 ? 1'((hb / 4) >> (3 - hb % 4)) : 1'b0;
            #1;
            if (h_in_valid && h_in_ready) hb++;
            if (h_cw_valid) got.push_back(h_cw_out);
            hc++;
        end
        h_in_valid = 1'b0;
        tests++; if (got.size() !== 16) begin fails++; $display("FAIL ham_count: got %0d exp 16", got.size()); end
        first = got.size() > 1 ? got[1] : 'x;
        tests++; if (first !== 7'h0B) begin fails++; $display("FAIL ham_m1: got %h exp 0b", first); end
        for (int i = 0; i < got.size() && i < 16; i++)
            if (got[i] !== 7'(model(32'(i), 7, 4, 32'hB))) e++;
        tests++; if (e !== 0) begin fails++; $display("FAIL ham_exhaustive: got %0d errors exp 0", e); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_backpressure();
        test_clr();
        test_rst_mid();
        test_hamming();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
